floppy_sector_fetch: RTL and testbench
======================================

Name: floppy_sector_fetch

Overview:
- Hardware workhorse that services sector requests from the wd1793 controller.
- Decodes `cpu_command`, maps track/side/sector to a linear block address and requests that block from the storage byte-stream port.
- Writes the returned bytes into the shared sector buffer, then reports completion on `cpu_status`.
- Sits directly downstream of wd1793's command outputs and upstream of its buffer read path; replaces the software loop.

Parameters:
- SECTOR_SIZE, 512, bytes per sector and bytes written to buffer per read
- SECTORS_PER_TRACK, 10, sectors per track; valid sector numbers are 1..SECTORS_PER_TRACK
- SIDES, 2, sides per track used in the LBA formula
- TIMEOUT, 16'hFFFF, clken cycles allowed between request/bytes before failing

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clken  in  1  clock enable; all state advances only when clken=1
- cpu_command  in  8  from wd1793; 8'h80 = ACK/idle, 8'h10|side = READ, 8'h30|side = READADDR (side in bit 0)
- track  in  8  physical head track from wd1793
- sector  in  8  sector register from wd1793
- cpu_status  out  8  bit0 = done, bit1 = success, bits7:2 = 0
- buff_addr  out  9  sector buffer write address
- buff_wr  out  1  sector buffer write strobe, one clken cycle per byte
- buff_odata  out  8  sector buffer write data
- blk_req  out  1  block read request, held until blk_ack
- blk_lba  out  32  block address, stable while blk_req=1
- blk_ack  in  1  storage accepted request
- blk_valid  in  1  one data byte present on blk_data (sampled only when clken=1)
- blk_data  in  8  data byte
- blk_err  in  1  storage error, any time after request

Behaviour:
- Reset (sync, overrides clken) values: cpu_status=0, buff_addr=0, buff_wr=0, buff_odata=0, blk_req=0, blk_lba=0, state=IDLE, counters=0. Reset mid-transfer abandons it; blk_req drops at once.
- IDLE: wait for cpu_command != 8'h80.
  - [7:4]=1 latches side=cpu_command[0], track and sector, then goes to CALC.
  - [7:4]=3 latches the same and goes to ADDR.
  - Any other non-ACK code goes to DONE with success=0.
- CALC (1 clken cycle):
  - If sector==0 or sector>SECTORS_PER_TRACK, go to DONE with fail; no storage access.
  - Otherwise blk_lba = (track*SIDES + side)*SECTORS_PER_TRACK + (sector-1), computed zero-extended to 32 bits with no wrap. Assert blk_req and go to REQ.
- REQ: hold blk_req/blk_lba until blk_ack=1, then drop blk_req, clear byte count and timer, go to XFER.
- XFER: on each blk_valid:
  - buff_odata=blk_data, buff_addr=count[8:0], buff_wr=1 for that clken cycle, count+1.
  - When count reaches SECTOR_SIZE, go to DONE with success=1. Bytes after that are ignored.
- Timer: reloads on ack and on each byte; expiry in REQ or XFER goes to DONE with fail and drops blk_req.
- blk_err in REQ/XFER goes to DONE with fail. If blk_err and blk_valid occur in the same cycle, the error wins and the byte is not written.
- ADDR: write 6 bytes, one per clken cycle, to addresses 0..5: track, side (0/1), sector, 8'h02 (512-byte size code), 8'h00, 8'h00. Then go to DONE with success=1.
- DONE: cpu_status = {6'b0, success, 1'b1}. Hold it until cpu_command==8'h80, then cpu_status=0 and return to IDLE the next clken cycle.
  - A non-ACK command in DONE is ignored.
  - If cpu_command is already ACK on entry, still show done for at least one clken cycle.
- buff_wr is never asserted outside XFER/ADDR. buff_addr holds its last value otherwise.
- clken=0 freezes all state and holds buff_wr low.

Test Plan:
- READ track 3, sector 5, side 1 (cmd 8'h11), SECTORS_PER_TRACK=10, SIDES=2 -> blk_lba=74. Supply 512 bytes 0..255 repeating -> buffer [0]=0, [511]=255, exactly 512 buff_wr pulses. cpu_status=8'h03 until ACK, then 8'h00.
- READ with sector=0 and with sector=11 -> no blk_req, cpu_status=8'h01.
- READADDR (cmd 8'h30), track 7, sector 2 -> buffer 0..5 = 07,00,02,02,00,00; cpu_status=8'h03.
- blk_err asserted after byte 100, coincident with blk_valid -> 100 writes only, cpu_status=8'h01. Timeout with blk_ack never given -> blk_req drops, status 8'h01.
- Reset asserted at byte 200 -> next cycle blk_req=0, buff_wr=0, cpu_status=0. A fresh READ then completes normally.
- clken toggling 1-in-4 during READ -> identical buffer contents and byte count. Command 8'h20 -> immediate cpu_status=8'h01.

Source files
------------

// File: rtl/floppy_sector_fetch.sv
// Sector fetch engine for the wd1793: turns READ/READADDR commands into a block
// request, streams the returned bytes into the sector buffer and reports status.
module floppy_sector_fetch #(
    parameter int          SECTOR_SIZE       = 512,
    parameter int          SECTORS_PER_TRACK = 10,
    parameter int          SIDES             = 2,
    parameter logic [15:0] TIMEOUT           = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clken,
    input  logic [7:0]  cpu_command,
    input  logic [7:0]  track,
    input  logic [7:0]  sector,
    output logic [7:0]  cpu_status,
    output logic [8:0]  buff_addr,
    output logic        buff_wr,
    output logic [7:0]  buff_odata,
    output logic        blk_req,
    output logic [31:0] blk_lba,
    input  logic        blk_ack,
    input  logic        blk_valid,
    input  logic [7:0]  blk_data,
    input  logic        blk_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_REQ, S_XFER, S_ADDR, S_DONE
    } state_t;

    state_t      state, state_n;
    logic        side_q, side_n;
    logic [7:0]  trk_q, trk_n;
    logic [7:0]  sec_q, sec_n;
    logic [9:0]  cnt, cnt_n;
    logic [15:0] timer, timer_n;
    logic [7:0]  status_n;
    logic [8:0]  addr_n;
    logic        wr_q, wr_n;
    logic [7:0]  odata_n;
    logic        req_n;
    logic [31:0] lba_n;
    logic [31:0] lba_calc;
    logic        sec_bad;

    localparam logic [7:0] ACK = 8'h80;

    // The strobe is qualified with clken so a frozen pipeline never writes.
    assign buff_wr = wr_q & clken;

    assign lba_calc = ({24'b0, trk_q} * 32'(SIDES) + {31'b0, side_q})
                      * 32'(SECTORS_PER_TRACK) + {24'b0, sec_q} - 32'd1;
    assign sec_bad  = (sec_q == 8'd0) ||
                      ({24'b0, sec_q} > 32'(SECTORS_PER_TRACK));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            side_q     <= 1'b0;
            trk_q      <= 8'd0;
            sec_q      <= 8'd0;
            cnt        <= 10'd0;
            timer      <= 16'd0;
            cpu_status <= 8'd0;
            buff_addr  <= 9'd0;
            wr_q       <= 1'b0;
            buff_odata <= 8'd0;
            blk_req    <= 1'b0;
            blk_lba    <= 32'd0;
        end else if (clken) begin
            state      <= state_n;
            side_q     <= side_n;
            trk_q      <= trk_n;
            sec_q      <= sec_n;
            cnt        <= cnt_n;
            timer      <= timer_n;
            cpu_status <= status_n;
            buff_addr  <= addr_n;
            wr_q       <= wr_n;
            buff_odata <= odata_n;
            blk_req    <= req_n;
            blk_lba    <= lba_n;
        end
    end

    always_comb begin
        state_n  = state;
        side_n   = side_q;
        trk_n    = trk_q;
        sec_n    = sec_q;
        cnt_n    = cnt;
        timer_n  = timer;
        status_n = cpu_status;
        addr_n   = buff_addr;
        wr_n     = 1'b0;
        odata_n  = buff_odata;
        req_n    = blk_req;
        lba_n    = blk_lba;
        case (state)
            S_IDLE: begin
                if (cpu_command != ACK) begin
                    side_n = cpu_command[0];
                    trk_n  = track;
                    sec_n  = sector;
                    cnt_n  = 10'd0;
                    case (cpu_command[7:4])
                        4'h1:    state_n = S_CALC;
                        4'h3:    state_n = S_ADDR;
                        default: begin
                            status_n = 8'h01;
                            state_n  = S_DONE;
                        end
                    endcase
                end
            end
            S_CALC: begin
                if (sec_bad) begin
                    status_n = 8'h01;
                    state_n  = S_DONE;
                end else begin
                    lba_n   = lba_calc;
                    req_n   = 1'b1;
                    timer_n = 16'd0;
                    state_n = S_REQ;
                end
            end
            S_REQ: begin
                if (blk_err || (!blk_ack && timer == TIMEOUT)) begin
                    req_n    = 1'b0;
                    status_n = 8'h01;
                    state_n  = S_DONE;
                end else if (blk_ack) begin
                    req_n   = 1'b0;
                    cnt_n   = 10'd0;
                    timer_n = 16'd0;
                    state_n = S_XFER;
                end else begin
                    timer_n = timer + 16'd1;
                end
            end
            S_XFER: begin
                // An error beats a coincident byte, so that byte is dropped.
                if (blk_err) begin
                    status_n = 8'h01;
                    state_n  = S_DONE;
                end else if (blk_valid) begin
                    wr_n    = 1'b1;
                    addr_n  = cnt[8:0];
                    odata_n = blk_data;
                    cnt_n   = cnt + 10'd1;
                    timer_n = 16'd0;
                    if (cnt == 10'(SECTOR_SIZE - 1)) begin
                        status_n = 8'h03;
                        state_n  = S_DONE;
                    end
                end else if (timer == TIMEOUT) begin
                    status_n = 8'h01;
                    state_n  = S_DONE;
                end else begin
                    timer_n = timer + 16'd1;
                end
            end
            S_ADDR: begin
                wr_n   = 1'b1;
                addr_n = cnt[8:0];
                case (cnt[2:0])
                    3'd0:    odata_n = trk_q;
                    3'd1:    odata_n = {7'b0, side_q};
                    3'd2:    odata_n = sec_q;
                    3'd3:    odata_n = 8'h02;
                    default: odata_n = 8'h00;
                endcase
                cnt_n = cnt + 10'd1;
                if (cnt == 10'd5) begin
                    status_n = 8'h03;
                    state_n  = S_DONE;
                end
            end
            S_DONE: begin
                if (cpu_command == ACK) begin
                    status_n = 8'h00;
                    state_n  = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_floppy_sector_fetch.sv
// Scoreboard bench for floppy_sector_fetch: stimulus queues expected LBAs,
// buffer writes and status changes; a negedge monitor pops and compares them.
module tb_floppy_sector_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clken = 1'b1;
    logic [7:0]  cpu_command = 8'h80;
    logic [7:0]  track = 8'd0;
    logic [7:0]  sector = 8'd0;
    logic [7:0]  cpu_status;
    logic [8:0]  buff_addr;
    logic        buff_wr;
    logic [7:0]  buff_odata;
    logic        blk_req;
    logic [31:0] blk_lba;
    logic        blk_ack = 1'b0;
    logic        blk_valid = 1'b0;
    logic [7:0]  blk_data = 8'd0;
    logic        blk_err = 1'b0;

    floppy_sector_fetch #(.TIMEOUT(16'd300)) dut (
        .clk(clk), .reset(reset), .clken(clken),
        .cpu_command(cpu_command), .track(track), .sector(sector),
        .cpu_status(cpu_status), .buff_addr(buff_addr),
        .buff_wr(buff_wr), .buff_odata(buff_odata),
        .blk_req(blk_req), .blk_lba(blk_lba), .blk_ack(blk_ack),
        .blk_valid(blk_valid), .blk_data(blk_data), .blk_err(blk_err)
    );

    always #5 clk = ~clk;

    int div = 1;
    int ph = 0;
    always begin
        @(posedge clk);
        #1;
        ph = (ph + 1 >= div) ? 0 : ph + 1;
        clken = (ph == 0);
    end

    int checks = 0;
    int passes = 0;
    logic [31:0] lq[$];
    logic [7:0]  sq[$];
    logic [16:0] wq[$];
    logic [7:0]  mem [0:511];
    int          wr_cnt = 0;
    bit          mon_en = 1'b0;
    logic        req_prev = 1'b0;
    logic [7:0]  st_prev = 8'd0;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (buff_wr) begin
                wr_cnt++;
                mem[buff_addr] = buff_odata;
                if (wq.size() == 0) begin
                    checks++;
                    $display("FAIL write_extra: addr %0d data %0h, none expected",
                             buff_addr, buff_odata);
                end else begin
                    chk("write", {15'b0, buff_addr, buff_odata}, {15'b0, wq.pop_front()});
                end
            end
            if (blk_req && !req_prev) begin
                if (lq.size() == 0) begin
                    checks++;
                    $display("FAIL req_extra: lba %0d, none expected", blk_lba);
                end else begin
                    chk("lba", blk_lba, lq.pop_front());
                end
            end
            if (cpu_status != st_prev) begin
                if (sq.size() == 0) begin
                    checks++;
                    $display("FAIL status_extra: got %0h, none expected", cpu_status);
                end else begin
                    chk("status", {24'b0, cpu_status}, {24'b0, sq.pop_front()});
                end
            end
            req_prev = blk_req;
            st_prev  = cpu_status;
        end
    end

    task automatic ce_edge();
        do @(posedge clk); while (!clken);
        #1;
    endtask

    function automatic bit cond(input int kind);
        case (kind)
            0:       return blk_req === 1'b1;
            1:       return cpu_status[0] === 1'b1;
            default: return cpu_status === 8'h00;
        endcase
    endfunction

    task automatic wait_for(input string nm, input int kind, input int lim);
        int n = 0;
        while (!cond(kind) && n < lim) begin
            ce_edge();
            n++;
        end
        if (!cond(kind)) begin
            checks++;
            $display("FAIL %s: timeout after %0d cycles, got none want event", nm, lim);
        end
    endtask

    task automatic finish_cmd(input int lim);
        wait_for("done", 1, lim);
        cpu_command = 8'h80;
        wait_for("idle", 2, 20);
        ce_edge();
    endtask

    task automatic start_read(input logic [7:0] c, input logic [7:0] t,
                              input logic [7:0] s, input logic [31:0] exp_lba);
        lq.push_back(exp_lba);
        cpu_command = c;
        track = t;
        sector = s;
        wait_for("req", 0, 20);
        blk_ack = 1'b1;
        ce_edge();
        blk_ack = 1'b0;
    endtask

    task automatic read_xfer(input int n_ok, input bit err);
        for (int i = 0; i < n_ok; i++) begin
            logic [8:0] a;
            a = 9'(i);
            wq.push_back({a, a[7:0]});
            blk_valid = 1'b1;
            blk_data = a[7:0];
            ce_edge();
        end
        if (err) begin
            blk_valid = 1'b1;
            blk_err = 1'b1;
            blk_data = 8'hEE;
            ce_edge();
            blk_err = 1'b0;
        end
        blk_valid = 1'b0;
    endtask

    int base;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_status", {24'b0, cpu_status}, 32'h0);
        chk("rst_req", {31'b0, blk_req}, 32'h0);
        chk("rst_wr", {31'b0, buff_wr}, 32'h0);
        chk("rst_lba", blk_lba, 32'h0);
        chk("rst_addr", {23'b0, buff_addr}, 32'h0);
        reset = 1'b0;
        req_prev = 1'b0;
        st_prev = 8'h00;
        mon_en = 1'b1;
        ce_edge();

        // READ t3 s5 side1: (3*2+1)*10+4 = 74, plus trailing bytes ignored
        base = wr_cnt;
        sq.push_back(8'h03); sq.push_back(8'h00);
        start_read(8'h11, 8'd3, 8'd5, 32'd74);
        read_xfer(512, 1'b0);
        blk_valid = 1'b1; blk_data = 8'h5A;
        ce_edge(); ce_edge();
        blk_valid = 1'b0;
        finish_cmd(50);
        chk("read_count", wr_cnt - base, 32'd512);
        chk("mem0", {24'b0, mem[0]}, 32'h00);
        chk("mem511", {24'b0, mem[511]}, 32'hFF);

        // bad sectors: no request, fail status
        sq.push_back(8'h01); sq.push_back(8'h00);
        cpu_command = 8'h10; track = 8'd2; sector = 8'd0;
        finish_cmd(20);
        sq.push_back(8'h01); sq.push_back(8'h00);
        cpu_command = 8'h10; track = 8'd2; sector = 8'd11;
        finish_cmd(20);

        // READADDR t7 s2 side0
        base = wr_cnt;
        sq.push_back(8'h03); sq.push_back(8'h00);
        wq.push_back({9'd0, 8'h07}); wq.push_back({9'd1, 8'h00});
        wq.push_back({9'd2, 8'h02}); wq.push_back({9'd3, 8'h02});
        wq.push_back({9'd4, 8'h00}); wq.push_back({9'd5, 8'h00});
        cpu_command = 8'h30; track = 8'd7; sector = 8'd2;
        finish_cmd(20);
        chk("addr_count", wr_cnt - base, 32'd6);

        // error coincident with byte 100
        base = wr_cnt;
        sq.push_back(8'h01); sq.push_back(8'h00);
        start_read(8'h11, 8'd3, 8'd5, 32'd74);
        read_xfer(100, 1'b1);
        finish_cmd(20);
        chk("err_count", wr_cnt - base, 32'd100);

        // timeout waiting for ack: (0*2+1)*10+0 = 10
        sq.push_back(8'h01); sq.push_back(8'h00);
        lq.push_back(32'd10);
        cpu_command = 8'h11; track = 8'd0; sector = 8'd1;
        wait_for("req_to", 0, 20);
        wait_for("timeout", 1, 400);
        chk("to_req", {31'b0, blk_req}, 32'h0);
        finish_cmd(20);

        // reset at byte 200, then a fresh READ t0 s1 side0 -> lba 0
        start_read(8'h10, 8'd0, 8'd1, 32'd0);
        read_xfer(200, 1'b0);
        cpu_command = 8'h80;
        blk_valid = 1'b1; blk_data = 8'hC8;
        reset = 1'b1;
        @(posedge clk);
        #1;
        blk_valid = 1'b0;
        reset = 1'b0;
        chk("mid_rst_req", {31'b0, blk_req}, 32'h0);
        chk("mid_rst_wr", {31'b0, buff_wr}, 32'h0);
        chk("mid_rst_status", {24'b0, cpu_status}, 32'h0);
        ce_edge();
        base = wr_cnt;
        sq.push_back(8'h03); sq.push_back(8'h00);
        start_read(8'h10, 8'd0, 8'd1, 32'd0);
        read_xfer(512, 1'b0);
        finish_cmd(50);
        chk("fresh_count", wr_cnt - base, 32'd512);

        // clken 1-in-4: READ t1 s10 side0 -> (1*2+0)*10+9 = 29
        div = 4;
        base = wr_cnt;
        sq.push_back(8'h03); sq.push_back(8'h00);
        start_read(8'h10, 8'd1, 8'd10, 32'd29);
        read_xfer(512, 1'b0);
        finish_cmd(50);
        div = 1;
        ce_edge();
        chk("slow_count", wr_cnt - base, 32'd512);
        chk("slow_mem300", {24'b0, mem[300]}, 32'h2C);
        chk("slow_mem511", {24'b0, mem[511]}, 32'hFF);

        // unknown command
        sq.push_back(8'h01); sq.push_back(8'h00);
        cpu_command = 8'h20;
        finish_cmd(5);

        repeat (4) ce_edge();
        chk("wq_empty", wq.size(), 32'd0);
        chk("lq_empty", lq.size(), 32'd0);
        chk("sq_empty", sq.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
